// File: rtl/cnn16_pkg.sv
// Shared constants and dumper FSM state type for the CNN16 memory dumper.
// CSUM states exist only when CNN16_DUMP_CHECKSUM_EN is defined.
package cnn16_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    WAIT    = 3'd2,
    SEND_HI = 3'd3,
    SEND_LO = 3'd4,
`ifdef CNN16_DUMP_CHECKSUM_EN
    CSUM_HI = 3'd5,
    CSUM_LO = 3'd6,
`endif
    FIN     = 3'd7
  } dump_state_e;

endpackage

// File: rtl/cnn16_mem_dumper.sv
// Streams a block of 16-bit RAM words out as bytes (high byte first) over a valid/ready link.
// Optional trailing 16-bit checksum when CNN16_DUMP_CHECKSUM_EN is defined.
module cnn16_mem_dumper
  import cnn16_pkg::*;
(
  input  logic              clkn,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_adr,
  input  logic [LEN_W-1:0]  length,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              done
);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
`ifdef CNN16_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
  logic              mem_re_q, mem_re_d;
  logic [BYTE_W-1:0] byte_out_q, byte_out_d;
  logic              byte_valid_q, byte_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
`ifdef CNN16_DUMP_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    mem_re_d     = 1'b0;
    mem_adr_d    = mem_adr_q;
    byte_valid_d = 1'b0;
    byte_out_d   = byte_out_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
`ifdef CNN16_DUMP_CHECKSUM_EN
          csum_d = '0;
`endif
          if (length != '0) begin
            adr_d   = start_adr;
            cnt_d   = length;
            state_d = READ;
          end else begin
            state_d = FIN;
          end
        end
      end
      READ: state_d = WAIT;
      WAIT: begin
        word_d  = mem_rdata;
`ifdef CNN16_DUMP_CHECKSUM_EN
        csum_d  = csum_q + mem_rdata;
`endif
        state_d = SEND_HI;
      end
      SEND_HI: begin
        if (byte_ready) state_d = SEND_LO;
      end
      SEND_LO: begin
        if (byte_ready) begin
          if (cnt_q > LEN_W'(1)) begin
            cnt_d   = cnt_q - LEN_W'(1);
            adr_d   = adr_q + ADDR_W'(1);
            state_d = READ;
          end else begin
`ifdef CNN16_DUMP_CHECKSUM_EN
            state_d = CSUM_HI;
`else
            state_d = FIN;
`endif
          end
        end
      end
`ifdef CNN16_DUMP_CHECKSUM_EN
      CSUM_HI: begin
        if (byte_ready) state_d = CSUM_LO;
      end
      CSUM_LO: begin
        if (byte_ready) state_d = FIN;
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the state being entered
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
    if (state_d == READ) begin
      mem_re_d  = 1'b1;
      mem_adr_d = adr_d;
    end
    unique case (state_d)
      SEND_HI: begin
        byte_valid_d = 1'b1;
        byte_out_d   = word_d[DATA_W-1:BYTE_W];
      end
      SEND_LO: begin
        byte_valid_d = 1'b1;
        byte_out_d   = word_d[BYTE_W-1:0];
      end
`ifdef CNN16_DUMP_CHECKSUM_EN
      CSUM_HI: begin
        byte_valid_d = 1'b1;
        byte_out_d   = csum_d[DATA_W-1:BYTE_W];
      end
      CSUM_LO: begin
        byte_valid_d = 1'b1;
        byte_out_d   = csum_d[BYTE_W-1:0];
      end
`endif
      default: byte_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clkn or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      adr_q        <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
`ifdef CNN16_DUMP_CHECKSUM_EN
      csum_q       <= '0;
`endif
      mem_adr_q    <= '0;
      mem_re_q     <= 1'b0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
`ifdef CNN16_DUMP_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
      mem_adr_q    <= mem_adr_d;
      mem_re_q     <= mem_re_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign mem_adr    = mem_adr_q;
  assign mem_re     = mem_re_q;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_cnn16_mem_dumper.sv
// Randomized self-checking bench for cnn16_mem_dumper with a synchronous RAM model
// and a word-list reference model of the expected byte stream.
module tb_cnn16_mem_dumper;

  logic        clkn = 1'b0;
  logic        rstn;
  logic        start;
  logic [11:0] start_adr;
  logic [12:0] length;
  logic [11:0] mem_adr;
  logic        mem_re;
  logic [15:0] mem_rdata;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;
  logic        done;

  logic [15:0] mem [4096];
  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int gb, ab, db;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [11:0] adr_q[$];
  logic [11:0] exp_adr_q[$];

`ifdef CNN16_DUMP_CHECKSUM_EN
  localparam int CSUM_BYTES = 2;
`else
  localparam int CSUM_BYTES = 0;
`endif

  always #5 clkn = ~clkn;

  cnn16_mem_dumper dut (
    .clkn(clkn), .rstn(rstn), .start(start), .start_adr(start_adr), .length(length),
    .mem_adr(mem_adr), .mem_re(mem_re), .mem_rdata(mem_rdata), .byte_out(byte_out),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy), .done(done)
  );

  // Synchronous RAM: data valid the cycle after mem_re
  always @(posedge clkn) if (mem_re) mem_rdata <= mem[mem_adr];

  // Monitor of accepted bytes, read addresses and done pulses
  always @(posedge clkn) begin
    if (byte_valid && byte_ready) got_q.push_back(byte_out);
    if (mem_re) adr_q.push_back(mem_adr);
    if (done) done_cnt++;
  end

  // Reference: n consecutive words (wrapping), high byte first, optional sum trailer
  task automatic build_exp(input logic [11:0] a, input int n);
    logic [11:0] ad;
    logic [15:0] w;
`ifdef CNN16_DUMP_CHECKSUM_EN
    logic [15:0] sum;
    sum = '0;
`endif
    exp_q.delete();
    exp_adr_q.delete();
    for (int i = 0; i < n; i++) begin
      ad = a + 12'(i);
      w  = mem[ad];
      exp_adr_q.push_back(ad);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
`ifdef CNN16_DUMP_CHECKSUM_EN
      sum = sum + w;
`endif
    end
`ifdef CNN16_DUMP_CHECKSUM_EN
    if (n > 0) begin
      exp_q.push_back(sum[15:8]);
      exp_q.push_back(sum[7:0]);
    end
`endif
  endtask

  function automatic int byte_diffs(input int base);
    int d = 0;
    if (got_q.size() - base != exp_q.size()) return -1;
    for (int i = 0; i < exp_q.size(); i++) if (got_q[base + i] !== exp_q[i]) d++;
    return d;
  endfunction

  function automatic int adr_diffs(input int base);
    int d = 0;
    if (adr_q.size() - base != exp_adr_q.size()) return -1;
    for (int i = 0; i < exp_adr_q.size(); i++) if (adr_q[base + i] !== exp_adr_q[i]) d++;
    return d;
  endfunction

  task automatic run_dump(input logic [11:0] a, input logic [12:0] n, input int rdy_pct,
                          input int glitch_at, output int cyc);
    gb = got_q.size(); ab = adr_q.size(); db = done_cnt;
    build_exp(a, int'(n));
    @(negedge clkn);
    start = 1'b1; start_adr = a; length = n;
    byte_ready = (int'($urandom_range(99)) < rdy_pct);
    @(negedge clkn);
    start = 1'b0;
    cyc = -1;
    for (int i = 0; i < 40000; i++) begin
      if (done_cnt != db) begin
        cyc = i;
        break;
      end
      start = (i == glitch_at);
      if (start) begin
        start_adr = 12'($urandom);
        length    = 13'($urandom_range(1, 8));
      end
      byte_ready = (int'($urandom_range(99)) < rdy_pct);
      @(negedge clkn);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; start_adr = '0; length = '0; byte_ready = 1'b0;
    repeat (3) @(negedge clkn);
    checks++; if (mem_adr !== 12'h000) begin failures++; $display("FAIL reset_mem_adr got %h want 000", mem_adr); end
    checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL reset_mem_re got %b want 0", mem_re); end
    checks++; if (byte_out !== 8'h00) begin failures++; $display("FAIL reset_byte_out got %h want 00", byte_out); end
    checks++; if (byte_valid !== 1'b0) begin failures++; $display("FAIL reset_byte_valid got %b want 0", byte_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done); end
    rstn = 1'b1;
    @(negedge clkn);
  endtask

  task automatic test_vector();
    logic [7:0] want [4];
    int d;
    want[0] = 8'hA1; want[1] = 8'hB2; want[2] = 8'hC3; want[3] = 8'hD4;
    mem[12'h010] = 16'hA1B2;
    mem[12'h011] = 16'hC3D4;
    gb = got_q.size(); db = done_cnt;
    build_exp(12'h010, 2);
    @(negedge clkn);
    start = 1'b1; start_adr = 12'h010; length = 13'd2; byte_ready = 1'b1;
    @(negedge clkn);
    start = 1'b0;
    checks++; if (mem_re !== 1'b1 || mem_adr !== 12'h010 || byte_valid !== 1'b0) begin
      failures++; $display("FAIL vec_read re=%b adr=%h valid=%b want 1/010/0", mem_re, mem_adr, byte_valid); end
    @(negedge clkn);
    checks++; if (mem_re !== 1'b0 || byte_valid !== 1'b0) begin
      failures++; $display("FAIL vec_wait re=%b valid=%b want 0/0", mem_re, byte_valid); end
    @(negedge clkn);
    checks++; if (byte_valid !== 1'b1 || byte_out !== 8'hA1) begin
      failures++; $display("FAIL vec_first_byte valid=%b out=%h want 1/a1", byte_valid, byte_out); end
    for (int i = 0; i < 50 && (got_q.size() - gb) < 4 + CSUM_BYTES; i++) @(negedge clkn);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL vec_done_pulse got %b want 1", done); end
    @(negedge clkn);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL vec_after_done done=%b busy=%b want 0/0", done, busy); end
    d = 0;
    if (got_q.size() - gb < 4) d = -1;
    else for (int i = 0; i < 4; i++) if (got_q[gb + i] !== want[i]) d++;
    checks++; if (d != 0) begin failures++; $display("FAIL vec_bytes diffs=%0d want 0 (a1 b2 c3 d4)", d); end
    checks++; if (byte_diffs(gb) != 0) begin failures++; $display("FAIL vec_stream diffs=%0d want 0", byte_diffs(gb)); end
  endtask

  task automatic test_wrap();
    int cyc;
    run_dump(12'hFFF, 13'd2, 100, -1, cyc);
    checks++; if (adr_q.size() - ab != 2 || adr_q[ab] !== 12'hFFF || adr_q[ab + 1] !== 12'h000) begin
      failures++; $display("FAIL wrap_addresses count=%0d want 2 (fff,000)", adr_q.size() - ab); end
    checks++; if (got_q.size() - gb != 4 + CSUM_BYTES) begin
      failures++; $display("FAIL wrap_byte_count got %0d want %0d", got_q.size() - gb, 4 + CSUM_BYTES); end
    checks++; if (cyc != 4 * 2 + 1 + CSUM_BYTES) begin
      failures++; $display("FAIL wrap_throughput cycles=%0d want %0d", cyc, 4 * 2 + 1 + CSUM_BYTES); end
  endtask

  task automatic test_stall();
    int d;
    mem[12'h010] = 16'hA1B2;
    gb = got_q.size(); db = done_cnt; ab = adr_q.size();
    build_exp(12'h010, 2);
    @(negedge clkn);
    start = 1'b1; start_adr = 12'h010; length = 13'd2; byte_ready = 1'b0;
    @(negedge clkn);
    start = 1'b0;
    repeat (2) @(negedge clkn);
    for (int k = 0; k < 5; k++) begin
      checks++; if (byte_valid !== 1'b1 || byte_out !== 8'hA1 || mem_re !== 1'b0) begin
        failures++; $display("FAIL stall_hold cyc%0d valid=%b out=%h re=%b want 1/a1/0", k, byte_valid, byte_out, mem_re); end
      @(negedge clkn);
    end
    checks++; if (adr_q.size() - ab != 1) begin
      failures++; $display("FAIL stall_reads got %0d want 1", adr_q.size() - ab); end
    byte_ready = 1'b1;
    for (int i = 0; i < 100 && done_cnt == db; i++) @(negedge clkn);
    checks++; if (done_cnt == db) begin failures++; $display("FAIL stall_done got none want 1 within 100 cycles"); end
    d = byte_diffs(gb);
    checks++; if (d != 0) begin failures++; $display("FAIL stall_stream diffs=%0d want 0", d); end
  endtask

  task automatic test_zero_len();
    gb = got_q.size(); ab = adr_q.size();
    @(negedge clkn);
    start = 1'b1; start_adr = 12'h123; length = 13'd0; byte_ready = 1'b1;
    @(negedge clkn);
    start = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL zero_done done=%b busy=%b want 1/1", done, busy); end
    @(negedge clkn);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL zero_idle done=%b busy=%b want 0/0", done, busy); end
    repeat (2) @(negedge clkn);
    checks++; if (adr_q.size() != ab || got_q.size() != gb) begin
      failures++; $display("FAIL zero_no_access reads=%0d bytes=%0d want 0/0", adr_q.size() - ab, got_q.size() - gb); end
  endtask

  task automatic test_reset_mid();
    int cyc, d;
    gb = got_q.size(); db = done_cnt;
    @(negedge clkn);
    start = 1'b1; start_adr = 12'($urandom); length = 13'd3; byte_ready = 1'b1;
    @(negedge clkn);
    start = 1'b0;
    for (int i = 0; i < 50 && (got_q.size() - gb) < 2; i++) @(negedge clkn);
    rstn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || byte_valid !== 1'b0 || mem_re !== 1'b0) begin
      failures++; $display("FAIL rstmid_async busy=%b valid=%b re=%b want 0/0/0", busy, byte_valid, mem_re); end
    @(negedge clkn);
    rstn = 1'b1;
    repeat (3) @(negedge clkn);
    checks++; if (done_cnt != db || got_q.size() - gb != 2) begin
      failures++; $display("FAIL rstmid_abort dones=%0d bytes=%0d want 0/2", done_cnt - db, got_q.size() - gb); end
    run_dump(12'($urandom), 13'd3, 100, -1, cyc);
    d = byte_diffs(gb);
    checks++; if (cyc < 0 || d != 0) begin
      failures++; $display("FAIL rstmid_restart cycles=%0d diffs=%0d want done/0", cyc, d); end
  endtask

  task automatic test_busy_ignore();
    int cyc, d;
    run_dump(12'($urandom), 13'd3, 100, 5, cyc);
    repeat (12) @(negedge clkn);
    d = byte_diffs(gb);
    checks++; if (done_cnt - db != 1 || busy !== 1'b0 || adr_q.size() - ab != 3) begin
      failures++; $display("FAIL ignore_start dones=%0d busy=%b reads=%0d want 1/0/3", done_cnt - db, busy, adr_q.size() - ab); end
    checks++; if (d != 0) begin failures++; $display("FAIL ignore_stream diffs=%0d want 0", d); end
  endtask

  task automatic test_random();
    int cyc, db_n, da_n, n, pct;
    for (int it = 0; it < 8; it++) begin
      n   = (it == 0) ? 1 : int'($urandom_range(1, 40));
      pct = int'($urandom_range(30, 100));
      run_dump(12'($urandom), 13'(n), pct, -1, cyc);
      db_n = byte_diffs(gb);
      da_n = adr_diffs(ab);
      checks++; if (cyc < 0 || db_n != 0 || da_n != 0) begin
        failures++; $display("FAIL rand%0d len=%0d cycles=%0d byte_diffs=%0d adr_diffs=%0d want 0/0", it, n, cyc, db_n, da_n); end
    end
  endtask

  task automatic test_full();
    int cyc, dup, miss, d;
    bit seen [4096];
    run_dump(12'($urandom), 13'd4096, 100, -1, cyc);
    dup = 0; miss = 0;
    for (int i = 0; i < 4096; i++) seen[i] = 1'b0;
    for (int i = ab; i < adr_q.size(); i++) begin
      if (seen[adr_q[i]]) dup++;
      seen[adr_q[i]] = 1'b1;
    end
    for (int i = 0; i < 4096; i++) if (!seen[i]) miss++;
    checks++; if (dup != 0 || miss != 0) begin
      failures++; $display("FAIL full_coverage dup=%0d missing=%0d want 0/0", dup, miss); end
    checks++; if (cyc != 4 * 4096 + 1 + CSUM_BYTES) begin
      failures++; $display("FAIL full_throughput cycles=%0d want %0d", cyc, 4 * 4096 + 1 + CSUM_BYTES); end
    d = byte_diffs(gb);
    checks++; if (d != 0) begin failures++; $display("FAIL full_stream diffs=%0d want 0", d); end
  endtask

`ifdef CNN16_DUMP_CHECKSUM_EN
  task automatic test_checksum();
    int cyc, d;
    logic [7:0] want [6];
    want[0] = 8'hFF; want[1] = 8'hFF; want[2] = 8'h00;
    want[3] = 8'h02; want[4] = 8'h00; want[5] = 8'h01;
    mem[12'h200] = 16'hFFFF;
    mem[12'h201] = 16'h0002;
    run_dump(12'h200, 13'd2, 70, -1, cyc);
    d = 0;
    if (got_q.size() - gb != 6) d = -1;
    else for (int i = 0; i < 6; i++) if (got_q[gb + i] !== want[i]) d++;
    checks++; if (cyc < 0 || d != 0) begin
      failures++; $display("FAIL csum_bytes cycles=%0d diffs=%0d want ff ff 00 02 00 01", cyc, d); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    test_reset();
    test_vector();
    test_wrap();
    test_stall();
    test_zero_len();
    test_reset_mid();
    test_busy_ignore();
    test_random();
`ifdef CNN16_DUMP_CHECKSUM_EN
    test_checksum();
`endif
    test_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
